// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, width defaults and opcode constants for the 4-bit CPU
package cpu_pkg;
    localparam int PC_W_DEF = 12;
    localparam int OP_W_DEF = 4;
    typedef enum logic [1:0] {HALT, FETCH, EXEC} state_t;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_OUT = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
endpackage

// File: rtl/pc_counter.sv
// pc_counter: program counter with load-over-increment priority and async reset
import cpu_pkg::*;
module pc_counter #(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);
    // load wins over inc; increment wraps modulo 2^PC_W
    always_ff @(posedge clock or posedge reset)
        if (reset)
            q <= '0;
        else
            q <= load ? d : inc ? q + PC_W'(1) : q;
endmodule

// File: rtl/fetch_exec_sequencer.sv
// fetch_exec_sequencer: HALT/FETCH/EXEC sequencing, PC, instruction latch and flags; optional BREAKPOINT_EN
import cpu_pkg::*;
module fetch_exec_sequencer #(
    parameter int PC_W = PC_W_DEF,
    parameter int OP_W = OP_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [2*OP_W-1:0] rom_data,
    input  logic              rom_ready,
    input  logic              inc_pc,
    input  logic              load_pc,
    input  logic              load_flags,
    input  logic [PC_W-1:0]   jump_target,
    input  logic              c_in,
    input  logic              z_in,
`ifdef BREAKPOINT_EN
    input  logic [PC_W-1:0]   bp_addr,
    output logic              bp_hit,
`endif
    output logic [PC_W-1:0]   pc,
    output logic [OP_W-1:0]   instr,
    output logic [OP_W-1:0]   oprnd,
    output logic              phase,
    output logic              c_flag,
    output logic              z_flag,
    output logic              exec_en,
    output logic              halted
);
    state_t st, st_nxt;
    logic fetch_ok, pc_load, pc_inc, bp_blk, bp_stop;
    assign fetch_ok = st == FETCH && rom_ready;
    assign pc_load  = st == EXEC && load_pc;
    assign pc_inc   = inc_pc && (st == EXEC || fetch_ok);
`ifdef BREAKPOINT_EN
    logic [PC_W-1:0] pc_nxt;
    assign pc_nxt  = pc_load ? jump_target : pc_inc ? pc + PC_W'(1) : pc;
    assign bp_stop = pc_nxt == bp_addr;
    assign bp_blk  = bp_hit;
    // breakpoint latches on a stopped EXEC exit and clears once run=0 is seen in HALT
    always_ff @(posedge clock or posedge reset)
        if (reset)
            bp_hit <= 1'b0;
        else if (st == EXEC && run && bp_stop)
            bp_hit <= 1'b1;
        else if (st == HALT && !run)
            bp_hit <= 1'b0;
`else
    assign bp_stop = 1'b0;
    assign bp_blk  = 1'b0;
`endif
    pc_counter #(.PC_W(PC_W)) u_pc (
        .clock(clock),
        .reset(reset),
        .load (pc_load),
        .inc  (pc_inc),
        .d    (jump_target),
        .q    (pc)
    );
    // state register
    always_ff @(posedge clock or posedge reset)
        if (reset)
            st <= HALT;
        else
            st <= st_nxt;
    // next state: FETCH stalls on rom_ready, EXEC is always one cycle, run only sampled in HALT/EXEC exit
    always_comb begin
        st_nxt = st;
        case (st)
            HALT:    st_nxt = run && !bp_blk ? FETCH : HALT;
            FETCH:   st_nxt = rom_ready ? EXEC : FETCH;
            EXEC:    st_nxt = run && !bp_stop ? FETCH : HALT;
            default: st_nxt = HALT;
        endcase
    end
    // opcode/operand captured on the accepted fetch
    always_ff @(posedge clock or posedge reset)
        if (reset)
            {instr, oprnd} <= '0;
        else if (fetch_ok)
            {instr, oprnd} <= rom_data;
    // flags only accept load_flags during EXEC
    always_ff @(posedge clock or posedge reset)
        if (reset)
            {c_flag, z_flag} <= 2'b00;
        else if (st == EXEC && load_flags)
            {c_flag, z_flag} <= {c_in, z_in};
    assign phase   = st == EXEC;
    assign exec_en = st == EXEC;
    assign halted  = st == HALT;
endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// tb_fetch_exec_sequencer: directed spec scenarios plus randomized run against a cycle reference model
module tb_fetch_exec_sequencer;
    localparam int M_HALT = 0, M_FETCH = 1, M_EXEC = 2;
    logic clock = 1'b0, reset = 1'b1, run = 1'b0, rom_ready = 1'b0;
    logic inc_pc = 1'b0, load_pc = 1'b0, load_flags = 1'b0, c_in = 1'b0, z_in = 1'b0;
    logic [7:0]  rom_data = 8'h00;
    logic [11:0] jump_target = 12'h000;
    logic [11:0] pc;
    logic [3:0]  instr, oprnd;
    logic        phase, c_flag, z_flag, exec_en, halted;
`ifdef BREAKPOINT_EN
    logic [11:0] bp_addr = 12'hFFF;
    logic        bp_hit;
`endif
    int          n_chk = 0, n_err = 0;
    int          m_st;
    logic [11:0] m_pc;
    logic [3:0]  m_instr, m_oprnd;
    logic        m_c, m_z, m_bp;

    fetch_exec_sequencer dut (
        .clock(clock), .reset(reset), .run(run), .rom_data(rom_data), .rom_ready(rom_ready),
        .inc_pc(inc_pc), .load_pc(load_pc), .load_flags(load_flags), .jump_target(jump_target),
        .c_in(c_in), .z_in(z_in),
`ifdef BREAKPOINT_EN
        .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
        .pc(pc), .instr(instr), .oprnd(oprnd), .phase(phase), .c_flag(c_flag), .z_flag(z_flag),
        .exec_en(exec_en), .halted(halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_HALT; m_pc = 12'h000; m_instr = 4'h0; m_oprnd = 4'h0;
        m_c = 1'b0; m_z = 1'b0; m_bp = 1'b0;
    endtask

    task automatic model_update();
        int np;
        bit bp_on;
`ifdef BREAKPOINT_EN
        bp_on = 1'b1;
`else
        bp_on = 1'b0;
`endif
        if (reset) begin
            model_reset();
            return;
        end
        if (m_st == M_HALT) begin
            if (!run) m_bp = 1'b0;
            else if (!m_bp) m_st = M_FETCH;
        end else if (m_st == M_FETCH) begin
            if (rom_ready) begin
                m_instr = rom_data[7:4];
                m_oprnd = rom_data[3:0];
                if (inc_pc) m_pc = 12'((int'(m_pc) + 1) % 4096);
                m_st = M_EXEC;
            end
        end else begin
            np = load_pc ? int'(jump_target) : inc_pc ? (int'(m_pc) + 1) % 4096 : int'(m_pc);
            m_pc = 12'(np);
            if (load_flags) begin
                m_c = c_in;
                m_z = z_in;
            end
            m_st = run ? M_FETCH : M_HALT;
`ifdef BREAKPOINT_EN
            if (run && bp_on && np == int'(bp_addr)) begin
                m_st = M_HALT;
                m_bp = 1'b1;
            end
`endif
        end
    endtask

    task automatic compare_all();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instr", 32'(instr), 32'(m_instr));
        chk("oprnd", 32'(oprnd), 32'(m_oprnd));
        chk("phase", 32'(phase), 32'(m_st == M_EXEC));
        chk("exec_en", 32'(exec_en), 32'(m_st == M_EXEC));
        chk("halted", 32'(halted), 32'(m_st == M_HALT));
        chk("c_flag", 32'(c_flag), 32'(m_c));
        chk("z_flag", 32'(z_flag), 32'(m_z));
`ifdef BREAKPOINT_EN
        chk("bp_hit", 32'(bp_hit), 32'(m_bp));
`endif
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        step();
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_pc", 32'(pc), 32'h000);
        reset = 1'b0;
        run = 1'b1; rom_ready = 1'b1; rom_data = 8'h4A; inc_pc = 1'b1;
        step();
        step();
        chk("t2_instr", 32'(instr), 32'h4);
        chk("t2_oprnd", 32'(oprnd), 32'hA);
        chk("t2_phase", 32'(phase), 32'd1);
        chk("t2_pc", 32'(pc), 32'h001);
        inc_pc = 1'b0; rom_ready = 1'b0;
        step();
        inc_pc = 1'b1; load_pc = 1'b1; load_flags = 1'b1; c_in = 1'b1; z_in = 1'b1; jump_target = 12'h777;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_pc", 32'(pc), 32'h001);
            chk("t3_instr", 32'(instr), 32'h4);
            chk("t3_phase", 32'(phase), 32'd0);
            chk("t3_exec_en", 32'(exec_en), 32'd0);
            chk("t3_c_flag", 32'(c_flag), 32'd0);
        end
        rom_ready = 1'b1; rom_data = 8'h3C; load_pc = 1'b0; load_flags = 1'b0;
        step();
        chk("t4_pre_pc", 32'(pc), 32'h002);
        load_pc = 1'b1; inc_pc = 1'b1; jump_target = 12'h3C0; load_flags = 1'b1; c_in = 1'b1; z_in = 1'b0;
        step();
        chk("t4_jump_pc", 32'(pc), 32'h3C0);
        chk("t5_c_flag", 32'(c_flag), 32'd1);
        chk("t5_z_flag", 32'(z_flag), 32'd0);
        rom_ready = 1'b0; load_pc = 1'b0; inc_pc = 1'b0; c_in = 1'b0; z_in = 1'b1;
        step();
        rom_ready = 1'b1;
        step();
        chk("t5_fetch_c", 32'(c_flag), 32'd1);
        chk("t5_fetch_z", 32'(z_flag), 32'd0);
        load_flags = 1'b0; load_pc = 1'b1; jump_target = 12'hFFF;
        step();
        chk("t4_max_pc", 32'(pc), 32'hFFF);
        load_pc = 1'b0; inc_pc = 1'b1;
        step();
        chk("t4_wrap_pc", 32'(pc), 32'h000);
        load_pc = 1'b1; inc_pc = 1'b0; jump_target = 12'h123;
        step();
        load_pc = 1'b0;
        step();
        chk("t1_pre_pc", 32'(pc), 32'h123);
        chk("t1_pre_phase", 32'(phase), 32'd1);
        load_pc = 1'b1; jump_target = 12'h456; load_flags = 1'b1; c_in = 1'b1; z_in = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("t1_pc", 32'(pc), 32'h000);
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_phase", 32'(phase), 32'd0);
        chk("t1_flags", 32'({c_flag, z_flag}), 32'd0);
        reset = 1'b0; load_pc = 1'b0; load_flags = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            reset       = $urandom_range(0, 299) == 0;
            run         = $urandom_range(0, 99) < 85;
            rom_ready   = $urandom_range(0, 99) < 70;
            inc_pc      = 1'($urandom);
            load_pc     = $urandom_range(0, 3) == 0;
            load_flags  = 1'($urandom);
            c_in        = 1'($urandom);
            z_in        = 1'($urandom);
            rom_data    = 8'($urandom);
            jump_target = $urandom_range(0, 7) == 0 ? 12'hFFF : 12'($urandom);
`ifdef BREAKPOINT_EN
            bp_addr     = m_pc + 12'($urandom_range(0, 3));
`endif
        end
`ifdef BREAKPOINT_EN
        reset = 1'b1;
        step();
        reset = 1'b0; bp_addr = 12'h005; run = 1'b1; rom_ready = 1'b1; load_pc = 1'b0; load_flags = 1'b0;
        for (int i = 0; i < 40; i++) begin
            inc_pc = m_st == M_FETCH;
            step();
            if (m_st == M_HALT) break;
        end
        chk("t6_pc", 32'(pc), 32'h005);
        chk("t6_bp_hit", 32'(bp_hit), 32'd1);
        chk("t6_halted", 32'(halted), 32'd1);
        inc_pc = 1'b0;
        step();
        step();
        chk("t6_hold", 32'(halted), 32'd1);
        run = 1'b0;
        step();
        chk("t6_clear", 32'(bp_hit), 32'd0);
        run = 1'b1;
        step();
        chk("t6_resume_pc", 32'(pc), 32'h005);
        chk("t6_resume_halted", 32'(halted), 32'd0);
        rom_data = 8'h91; inc_pc = 1'b1;
        step();
        chk("t6_instr", 32'(instr), 32'h9);
        inc_pc = 1'b0;
        step();
        chk("t6_continue", 32'(halted), 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
